// File: rtl/exec_alu_unit.sv
// exec_alu_unit: execute stage with ALU control decode, ALU, PC+4, branch target and branch decision.
// Decode is combinational; every datapath result is registered with one-cycle latency.
module exec_alu_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [1:0]       alu_op,
    input  logic [10:0]      opcode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm,
    input  logic             branch,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target,
    output logic             take_branch,
    output logic             illegal,
    output logic             valid_out
);
    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;

    logic [3:0]       w_ctrl;
    logic             w_illegal;
    logic [WIDTH-1:0] w_result;
    logic             w_zero;

    always_comb begin
        w_ctrl    = alu_op == 2'b00   ? 4'b0010 :
                    alu_op[0]         ? 4'b0111 :
                    opcode == OP_SUB  ? 4'b0110 :
                    opcode == OP_AND  ? 4'b0000 :
                    opcode == OP_ORR  ? 4'b0001 : 4'b0010;
        w_illegal = alu_op == 2'b10 && opcode != OP_ADD && opcode != OP_SUB &&
                    opcode != OP_AND && opcode != OP_ORR;
    end

    always_comb begin
        w_result = '0;
        case (w_ctrl)
            4'b0000: w_result = operand_a & operand_b;
            4'b0001: w_result = operand_a | operand_b;
            4'b0010: w_result = operand_a + operand_b;
            4'b0110: w_result = operand_a + ~operand_b + WIDTH'(1);
            4'b0111: w_result = operand_b;
            4'b1100: w_result = ~(operand_a | operand_b);
            default: w_result = '0;
        endcase
        w_zero = w_result == '0;
    end

    assign alu_ctrl = w_ctrl;

    // Idle cycles drop the single-cycle flags but keep the datapath values.
    always_ff @(posedge clk) begin
        if (reset) begin
            result        <= '0;
            zero          <= 1'b1;
            pc_plus4      <= '0;
            branch_target <= '0;
            take_branch   <= 1'b0;
            illegal       <= 1'b0;
            valid_out     <= 1'b0;
        end else if (valid_in) begin
            result        <= w_result;
            zero          <= w_zero;
            pc_plus4      <= pc + WIDTH'(4);
            branch_target <= pc + (imm << 2);
            take_branch   <= branch & w_zero;
            illegal       <= w_illegal;
            valid_out     <= 1'b1;
        end else begin
            take_branch   <= 1'b0;
            illegal       <= 1'b0;
            valid_out     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_exec_alu_unit.sv
// tb_exec_alu_unit: directed vectors with a scoreboard queue checked by a negedge monitor.
module tb_exec_alu_unit;
    typedef struct packed {
        logic [63:0] res;
        logic        z;
        logic [63:0] pc4;
        logic [63:0] bt;
        logic        tb;
        logic        ill;
    } exp_t;

    logic        clk, reset, valid_in, branch;
    logic [1:0]  alu_op;
    logic [10:0] opcode;
    logic [63:0] operand_a, operand_b, pc, imm;
    logic [3:0]  alu_ctrl;
    logic [63:0] result, pc_plus4, branch_target;
    logic        zero, take_branch, illegal, valid_out;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    exec_alu_unit #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .alu_op(alu_op), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b), .pc(pc), .imm(imm), .branch(branch),
        .alu_ctrl(alu_ctrl), .result(result), .zero(zero), .pc_plus4(pc_plus4),
        .branch_target(branch_target), .take_branch(take_branch), .illegal(illegal),
        .valid_out(valid_out)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (q.size() == 0) chk("spurious_valid", {63'b0, valid_out}, 64'd0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("result", result, e.res);
                chk("zero", {63'b0, zero}, {63'b0, e.z});
                chk("pc_plus4", pc_plus4, e.pc4);
                chk("branch_target", branch_target, e.bt);
                chk("take_branch", {63'b0, take_branch}, {63'b0, e.tb});
                chk("illegal", {63'b0, illegal}, {63'b0, e.ill});
            end
        end
    end

    task automatic drive(input logic [1:0] op, input logic [10:0] oc, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] p, input logic [63:0] im,
                         input logic br);
        alu_op = op; opcode = oc; operand_a = a; operand_b = b; pc = p; imm = im; branch = br;
        valid_in = 1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [10:0] oc, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] p, input logic [63:0] im,
                         input logic br, input logic [3:0] ctrl, input exp_t e);
        drive(op, oc, a, b, p, im, br);
        #1;
        chk("alu_ctrl", {60'b0, alu_ctrl}, {60'b0, ctrl});
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic [63:0] hold_res);
        valid_in = 0;
        @(posedge clk); #1;
        chk("idle_valid_out", {63'b0, valid_out}, 64'd0);
        chk("idle_take_branch", {63'b0, take_branch}, 64'd0);
        chk("idle_illegal", {63'b0, illegal}, 64'd0);
        chk("idle_result_hold", result, hold_res);
    endtask

    task automatic chk_reset_state();
        chk("rst_result", result, 64'd0);
        chk("rst_zero", {63'b0, zero}, 64'd1);
        chk("rst_pc_plus4", pc_plus4, 64'd0);
        chk("rst_branch_target", branch_target, 64'd0);
        chk("rst_take_branch", {63'b0, take_branch}, 64'd0);
        chk("rst_illegal", {63'b0, illegal}, 64'd0);
        chk("rst_valid_out", {63'b0, valid_out}, 64'd0);
    endtask

    initial begin
        reset = 1; valid_in = 0; alu_op = 0; opcode = 0; operand_a = 0; operand_b = 0;
        pc = 0; imm = 0; branch = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state();
        reset = 0;
        issue(2'b10, 11'b11001011000, 64'd5, 64'd5, 64'h0, 64'h0, 1'b0, 4'b0110,
              '{64'd0, 1'b1, 64'h4, 64'h0, 1'b0, 1'b0});
        issue(2'b10, 11'b10001011000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h200, 64'd1, 1'b0, 4'b0010,
              '{64'd0, 1'b1, 64'h204, 64'h204, 1'b0, 1'b0});
        issue(2'b01, 11'b0, 64'h55, 64'd0, 64'h100, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 4'b0111,
              '{64'd0, 1'b1, 64'h104, 64'hF8, 1'b1, 1'b0});
        issue(2'b10, 11'b10101010000, 64'hF0, 64'h0F, 64'h10, 64'd3, 1'b0, 4'b0001,
              '{64'hFF, 1'b0, 64'h14, 64'h1C, 1'b0, 1'b0});
        issue(2'b10, 11'b10001010000, 64'hF0, 64'h0F, 64'h0, 64'h0, 1'b1, 4'b0000,
              '{64'd0, 1'b1, 64'h4, 64'h0, 1'b1, 1'b0});
        idle(64'd0);
        issue(2'b10, 11'b11111111111, 64'd3, 64'd4, 64'h0, 64'h0, 1'b0, 4'b0010,
              '{64'd7, 1'b0, 64'h4, 64'h0, 1'b0, 1'b1});
        idle(64'd7);
        issue(2'b00, 11'b11111111111, 64'h1000, 64'h20, 64'h40, 64'h2, 1'b0, 4'b0010,
              '{64'h1020, 1'b0, 64'h44, 64'h48, 1'b0, 1'b0});
        issue(2'b11, 11'b0, 64'h1, 64'hABCD, 64'h0, 64'h0, 1'b1, 4'b0111,
              '{64'hABCD, 1'b0, 64'h4, 64'h0, 1'b0, 1'b0});
        issue(2'b10, 11'b11001011000, 64'd3, 64'd5, 64'h0, 64'h0, 1'b0, 4'b0110,
              '{64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'h4, 64'h0, 1'b0, 1'b0});
        issue(2'b00, 11'b0, 64'd0, 64'd0, 64'h0, 64'h4000_0000_0000_0001, 1'b0, 4'b0010,
              '{64'd0, 1'b1, 64'h4, 64'h4, 1'b0, 1'b0});
        issue(2'b00, 11'b0, 64'd1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 1'b1, 4'b0010,
              '{64'd2, 1'b0, 64'h2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});
        reset = 1;
        drive(2'b10, 11'b10001011000, 64'd9, 64'd9, 64'h300, 64'h1, 1'b1);
        @(posedge clk); #1;
        chk_reset_state();
        reset = 0;
        issue(2'b10, 11'b10001011000, 64'd9, 64'd9, 64'h300, 64'h1, 1'b1, 4'b0010,
              '{64'd18, 1'b0, 64'h304, 64'h304, 1'b0, 1'b0});
        valid_in = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/exec_alu_unit.md
EXEC_ALU_UNIT -- requirements
Module: exec_alu_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 64, giving the datapath width in bits.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit, SHALL be the reset, which is synchronous and active-high.
REQ-004 Port valid_in, input, 1 bit, SHALL qualify the inputs for the current cycle.
REQ-005 Port alu_op, input, 2 bits, SHALL be the ALU operation class from the control unit.
REQ-006 Port opcode, input, 11 bits, SHALL be instruction bits [31:21].
REQ-007 Ports operand_a and operand_b, input, WIDTH each, SHALL be register data 1 and the already-selected second operand.
REQ-008 Port pc, input, WIDTH, SHALL be the current instruction address.
REQ-009 Port imm, input, WIDTH, SHALL be the sign-extended immediate.
REQ-010 Port branch, input, 1 bit, SHALL be the conditional-branch control bit.
REQ-011 Port alu_ctrl, output, 4 bits, SHALL be the combinational decoded ALU code.
REQ-012 Registered outputs SHALL be result (WIDTH), zero (1), pc_plus4 (WIDTH), branch_target (WIDTH), take_branch (1), illegal (1) and valid_out (1).

Function
REQ-013 alu_ctrl SHALL be decoded combinationally from alu_op and opcode:
- alu_op 00 -> 0010 (ADD, load/store address).
- alu_op 01 or 11 -> 0111 (pass operand_b, CBZ).
- alu_op 10 -> decoded from opcode per REQ-014.
REQ-014 When alu_op is 10, opcode SHALL decode as follows:
- 10001011000 -> 0010 (ADD).
- 11001011000 -> 0110 (SUB).
- 10001010000 -> 0000 (AND).
- 10101010000 -> 0001 (ORR).
- Any other opcode -> 0010, and the illegal condition is set.
REQ-015 The ALU SHALL compute on operand_a (A) and operand_b (B) according to alu_ctrl:
- 0000 A&B; 0001 A|B; 0010 A+B; 0110 A-B; 0111 B; 1100 ~(A|B).
- Any other code -> 0.
REQ-016 Add and subtract SHALL wrap modulo 2^WIDTH with no carry or overflow outputs; subtract is two's complement (A + ~B + 1).
REQ-017 The zero signal SHALL be 1 exactly when the WIDTH-bit ALU result equals 0.
REQ-018 pc_plus4 SHALL be pc + 4, modulo 2^WIDTH.
REQ-019 branch_target SHALL be pc + (imm << 2), modulo 2^WIDTH; the top two bits of imm are discarded.
REQ-020 take_branch SHALL be branch AND zero, computed from the same cycle's ALU result.
REQ-021 On a rising clk edge with valid_in=1 and reset=0, all registered outputs SHALL load their new values, and valid_out SHALL become 1.
REQ-022 On a rising clk edge with valid_in=0 and reset=0:
- valid_out SHALL become 0.
- take_branch and illegal SHALL become 0.
- result, zero, pc_plus4 and branch_target SHALL hold their values.
REQ-023 Latency SHALL be exactly one cycle from inputs to registered outputs, with throughput of one operation per cycle and no stall or backpressure.
REQ-024 alu_ctrl SHALL have zero latency and SHALL NOT depend on reset or valid_in.

Reset
REQ-025 When reset=1 at a rising clk edge, the following SHALL be cleared, taking priority over valid_in:
- result, pc_plus4 and branch_target to 0.
- take_branch, illegal and valid_out to 0.
- zero to 1, consistent with result = 0.
REQ-026 If reset is asserted while an operation is being captured, that operation SHALL be discarded; the first valid output appears one cycle after the first valid_in=1 edge with reset=0.

Verification
REQ-027 Set alu_op=10, opcode=11001011000, A=5, B=5, branch=0, valid_in=1 -> next cycle result=0, zero=1, take_branch=0, alu_ctrl=0110 immediately.
REQ-028 Set alu_op=10, opcode=10001011000, A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> result=0, zero=1 (wrap-around).
REQ-029 Set alu_op=01, B=0, branch=1, pc=0x100, imm=-2 -> take_branch=1, branch_target=0xF8, pc_plus4=0x104.
REQ-030 Set alu_op=10, opcode=10101010000, A=0xF0, B=0x0F -> result=0xFF, zero=0; then opcode=10001010000 -> result=0.
REQ-031 Set alu_op=10, opcode=11111111111 -> illegal=1, alu_ctrl=0010, result=A+B.
REQ-032 Hold valid_in=1 and assert reset for one cycle -> the next cycle shows all outputs at reset values (zero=1, valid_out=0), and normal outputs resume one cycle after reset deasserts.
